sram_mem_responder: RTL and testbench

//  Responder end of the MEM-stage data-memory interface: accepts one 32-bit word read or write
//  per request from the pipeline's MEM stage and services it on an external 16-bit asynchronous

---
 rtl/sram_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_sram_mem_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_responder.sv
// Purpose : MEM-stage data-memory responder; one 32-bit word access as two 16-bit async SRAM accesses.
// Latency : request seen in IDLE at cycle 0 -> ready=1 at cycle 2*(WAIT_CYCLES+1)+1, for one cycle.
// Backpr. : ready=0 freezes the pipeline while an access is pending; the request is latched in IDLE.
//
// Ports: clk/rst (synchronous, active-low); rd_en/wr_en/address/write_data from the MEM stage;
//        read_data/ready back to the pipeline; sram_dq/sram_addr/sram_we_n/sram_oe_n to the SRAM pins.
// Optional feature macro: MEM_RESP_RANGE_CHECK_EN adds output range_err and rejects out-of-range
// requests without touching the SRAM. Without it, out-of-range addresses wrap modulo the SRAM size.
module sram_mem_responder #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [15:0]            sram_dq,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
`ifdef MEM_RESP_RANGE_CHECK_EN
  ,
  output logic                   range_err
`endif
);

  localparam int unsigned WORD_W   = SRAM_ADDR_W - 1;
  localparam logic [2:0]  LAST_CNT = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              wr_op_q, wr_op_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       lo_buf_q, lo_buf_d;
  logic [31:0]       read_data_q, read_data_d;

  logic [31:0]       offset;
  logic [29:0]       word_full;
  logic              last_cyc;
  logic              dq_oe;
  logic [15:0]       dq_out;
  logic              unused_bits;

`ifdef MEM_RESP_RANGE_CHECK_EN
  localparam logic [29:0] WORD_LIMIT = 30'(1) << WORD_W;
  logic range_err_q, range_err_d;
  logic out_of_range;
  assign out_of_range = (address < 32'(BASE_ADDR)) || (word_full >= WORD_LIMIT);
  assign range_err    = range_err_q;
`endif

  // Word index relative to the SRAM base; the upper bits are dropped so addresses wrap.
  assign offset    = address - 32'(BASE_ADDR);
  assign word_full = offset[31:2];
  assign last_cyc  = (cnt_q == LAST_CNT);

  assign unused_bits = ^{offset[1:0], word_full[29:WORD_W]};

  assign read_data = read_data_q;
  assign sram_dq   = dq_oe ? dq_out : 16'bz;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_op_d     = wr_op_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    lo_buf_d    = lo_buf_q;
    read_data_d = read_data_q;
`ifdef MEM_RESP_RANGE_CHECK_EN
    range_err_d = 1'b0;
`endif
    ready       = 1'b0;
    sram_addr   = '0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    dq_oe       = 1'b0;
    dq_out      = '0;

    case (state_q)
      IDLE: begin
        // While reset is held the pipeline must not be frozen, even with a request present.
        ready = ~rst | ~(rd_en | wr_en);
        if (rd_en | wr_en) begin
          wr_op_d = wr_en;  // read+write together is serviced as a write
          word_d  = word_full[WORD_W-1:0];
          wdata_d = write_data;
          cnt_d   = '0;
          state_d = LO;
`ifdef MEM_RESP_RANGE_CHECK_EN
          if (out_of_range) begin
            state_d     = DONE;
            range_err_d = 1'b1;
          end
`endif
        end
      end

      LO, HI: begin
        sram_addr = {word_q, state_q == HI};
        if (wr_op_q) begin
          dq_oe     = 1'b1;
          dq_out    = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
          // Strobe released on the last cycle so address and data are held past we_n rising.
          sram_we_n = last_cyc;
        end else begin
          sram_oe_n = 1'b0;
        end

        if (last_cyc) begin
          cnt_d = '0;
          if (state_q == LO) begin
            state_d = HI;
            if (!wr_op_q) lo_buf_d = sram_dq;
          end else begin
            state_d = DONE;
            // Low half is buffered so read_data changes only when the whole word is in.
            if (!wr_op_q) read_data_d = {sram_dq, lo_buf_q};
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_op_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      lo_buf_q    <= '0;
      read_data_q <= '0;
`ifdef MEM_RESP_RANGE_CHECK_EN
      range_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_op_q     <= wr_op_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      lo_buf_q    <= lo_buf_d;
      read_data_q <= read_data_d;
`ifdef MEM_RESP_RANGE_CHECK_EN
      range_err_q <= range_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Bench for sram_mem_responder: SRAM device model, per-cycle expectation queue built from the
// access rules, one negedge compare process, directed literal checks and randomized traffic.
module tb_sram_mem_responder;

  localparam int BASE  = 1024;
  localparam int AW    = 18;
  localparam int W     = 2;
  localparam int PH    = W + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  wire  [31:0] read_data;
  wire         ready;
  wire  [15:0] sram_dq;
  wire  [AW-1:0] sram_addr;
  wire         sram_we_n;
  wire         sram_oe_n;
`ifdef MEM_RESP_RANGE_CHECK_EN
  wire         range_err;
`endif

  sram_mem_responder #(.BASE_ADDR(BASE), .SRAM_ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .sram_dq(sram_dq),
    .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
`ifdef MEM_RESP_RANGE_CHECK_EN
    , .range_err(range_err)
`endif
  );

  always #5 clk = ~clk;

  // External SRAM device
  logic [15:0] sram_mem [0:(1<<AW)-1];
  assign sram_dq = (!sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 16'bz;
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;

  // Reference model state
  typedef struct {
    bit          ready;
    bit [AW-1:0] addr;
    bit          we_n;
    bit          oe_n;
    bit          dq_chk;
    bit [15:0]   dq;
    bit [31:0]   rdata;
    bit          rerr;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_mem [int];
  logic [31:0] model_rdata = '0;
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_err = 0;

  // Observations of the most recent do_access, indexed by cycle from request
  logic [AW-1:0] obs_addr [0:15];
  logic [15:0]   obs_dq   [0:15];
  logic          obs_we   [0:15];
  logic          obs_oe   [0:15];
  logic          obs_rdy  [0:15];
  logic [31:0]   obs_rd   [0:15];
  logic          obs_err  [0:15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] sram_lo(input logic [31:0] a);
    logic [31:0] word;
    word = (a - BASE) >> 2;
    return AW'(word * 2);
  endfunction

  function automatic bit is_oor(input logic [31:0] a);
`ifdef MEM_RESP_RANGE_CHECK_EN
    logic [31:0] word;
    word = (a - BASE) >> 2;
    return (a < BASE) || (word >= (32'd1 << (AW - 1)));
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic logic [15:0] mem_get(input logic [AW-1:0] x);
    return ref_mem.exists(int'(x)) ? ref_mem[int'(x)] : 16'h0;
  endfunction

  // Expected outputs for every cycle of one access, cycle 0 = request seen in IDLE
  task automatic push_access(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, output int len);
    bit          is_wr, oor;
    logic [AW-1:0] lo_a, hi_a;
    logic [31:0] new_rd;
    int          ph, pos;
    exp_t        e;
    is_wr  = wr;
    oor    = is_oor(a);
    lo_a   = sram_lo(a);
    hi_a   = lo_a + 1'b1;
    len    = oor ? 1 : 2 * PH + 1;
    new_rd = model_rdata;
    if (!is_wr && !oor && rd) new_rd = {mem_get(hi_a), mem_get(lo_a)};
    for (int k = 0; k <= len; k++) begin
      e.ready  = (k == len);
      e.addr   = '0;
      e.we_n   = 1'b1;
      e.oe_n   = 1'b1;
      e.dq_chk = 1'b0;
      e.dq     = '0;
      e.rdata  = (k == len) ? new_rd : model_rdata;
      e.rerr   = oor && (k == len);
      if (!oor && k >= 1 && k <= 2 * PH) begin
        ph     = (k - 1) / PH;
        pos    = (k - 1) % PH;
        e.addr = (ph != 0) ? hi_a : lo_a;
        if (is_wr) begin
          e.we_n   = (pos == PH - 1);
          e.dq_chk = 1'b1;
          e.dq     = (ph != 0) ? d[31:16] : d[15:0];
        end else begin
          e.oe_n = 1'b0;
        end
      end
      exp_q.push_back(e);
    end
    model_rdata = new_rd;
    if (is_wr && !oor) begin
      ref_mem[int'(lo_a)] = d[15:0];
      ref_mem[int'(hi_a)] = d[31:16];
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e.ready = ~(rd_en | wr_en); e.addr = '0; e.we_n = 1'b1; e.oe_n = 1'b1;
        e.dq_chk = 1'b0; e.dq = '0; e.rdata = model_rdata; e.rerr = 1'b0;
      end
      chk("ready", 32'(ready), 32'(e.ready));
      chk("sram_addr", 32'(sram_addr), 32'(e.addr));
      chk("sram_we_n", 32'(sram_we_n), 32'(e.we_n));
      chk("sram_oe_n", 32'(sram_oe_n), 32'(e.oe_n));
      chk("read_data", read_data, e.rdata);
      if (e.dq_chk) chk("sram_dq", 32'(sram_dq), 32'(e.dq));
`ifdef MEM_RESP_RANGE_CHECK_EN
      chk("range_err", 32'(range_err), 32'(e.rerr));
`endif
    end
  end

  task automatic sample(input int k);
    obs_addr[k] = sram_addr;
    obs_dq[k]   = sram_dq;
    obs_we[k]   = sram_we_n;
    obs_oe[k]   = sram_oe_n;
    obs_rdy[k]  = ready;
    obs_rd[k]   = read_data;
`ifdef MEM_RESP_RANGE_CHECK_EN
    obs_err[k]  = range_err;
`else
    obs_err[k]  = 1'b0;
`endif
  endtask

  task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int len;
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    push_access(rd, wr, a, d, len);
    @(negedge clk); sample(0);
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin
        address    = $urandom;
        write_data = $urandom;
      end
      if (k == len) begin
        rd_en = 1'b0; wr_en = 1'b0;
      end
      @(negedge clk); sample(k);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [31:0] a, d;
    int op;

    // Reset held with a pending read
    rst = 1'b0; rd_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk_en = 1'b1;

    // Write 0xCAFE1234 at byte 1028
    do_access(1'b0, 1'b1, 32'd1028, 32'hCAFE_1234);
    chk("wr_lo_addr", 32'(obs_addr[1]), 32'd2);
    chk("wr_lo_dq", 32'(obs_dq[1]), 32'h1234);
    chk("wr_hi_addr", 32'(obs_addr[4]), 32'd3);
    chk("wr_hi_dq", 32'(obs_dq[4]), 32'hCAFE);
    cnt = 0; for (int k = 1; k <= 3; k++) if (!obs_we[k]) cnt++;
    chk("wr_lo_we_cycles", 32'(cnt), 32'd2);
    cnt = 0; for (int k = 4; k <= 6; k++) if (!obs_we[k]) cnt++;
    chk("wr_hi_we_cycles", 32'(cnt), 32'd2);
    cnt = 0; for (int k = 0; k <= 7; k++) if (!obs_rdy[k]) cnt++;
    chk("wr_ready_low_cycles", 32'(cnt), 32'd7);
    chk("wr_ready_c7", 32'(obs_rdy[7]), 32'd1);

    // Read it back, then a write must leave read_data alone
    do_access(1'b1, 1'b0, 32'd1028, 32'h0);
    chk("rd_data", obs_rd[7], 32'hCAFE_1234);
    chk("rd_oe_lo", 32'(obs_oe[1]), 32'd0);
    do_access(1'b0, 1'b1, 32'd1036, 32'h1111_2222);
    @(negedge clk);
    chk("rd_data_after_wr", read_data, 32'hCAFE_1234);

    // Read and write together act as a write
    do_access(1'b1, 1'b1, 32'd1032, 32'h0000_00FF);
    chk("both_lo_addr", 32'(obs_addr[1]), 32'd4);
    chk("both_hi_addr", 32'(obs_addr[4]), 32'd5);
    chk("both_oe_lo", 32'(obs_oe[1]), 32'd1);
    chk("both_oe_hi", 32'(obs_oe[5]), 32'd1);
    chk("both_dq_lo", 32'(obs_dq[1]), 32'h00FF);
    chk("both_dq_hi", 32'(obs_dq[4]), 32'h0000);
    do_access(1'b1, 1'b0, 32'd1032, 32'h0);
    chk("both_readback", obs_rd[7], 32'h0000_00FF);

    // Address below the base
    do_access(1'b0, 1'b1, 32'd1020, 32'h5555_AAAA);
`ifdef MEM_RESP_RANGE_CHECK_EN
    chk("oor_ready_c1", 32'(obs_rdy[1]), 32'd1);
    chk("oor_err_c1", 32'(obs_err[1]), 32'd1);
    chk("oor_we_c0", 32'(obs_we[0]), 32'd1);
    do_access(1'b1, 1'b0, 32'd1020, 32'h0);
    chk("oor_rd_ready_c1", 32'(obs_rdy[1]), 32'd1);
    chk("oor_rd_oe_c1", 32'(obs_oe[1]), 32'd1);
    chk("oor_rd_data", obs_rd[1], 32'h0000_00FF);
`else
    chk("wrap_lo_addr", 32'(obs_addr[1]), 32'(2**18 - 2));
    chk("wrap_hi_addr", 32'(obs_addr[4]), 32'(2**18 - 1));
    do_access(1'b1, 1'b0, 32'd1020, 32'h0);
    chk("wrap_rd_addr", 32'(obs_addr[1]), 32'(2**18 - 2));
    chk("wrap_rd_data", obs_rd[7], 32'h5555_AAAA);
`endif

    // Reset during the high phase of a write
    chk_en = 1'b0;
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1040; write_data = 32'hA5A5_5A5A;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_hi_we", 32'(sram_we_n), 32'd0);
    chk("mid_hi_addr", 32'(sram_addr), 32'd9);
    rst = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_we", 32'(sram_we_n), 32'd1);
    chk("mid_rst_oe", 32'(sram_oe_n), 32'd1);
    chk("mid_rst_addr", 32'(sram_addr), 32'd0);
    chk("mid_rst_rdata", read_data, 32'd0);
    // Both halves were strobed before the reset edge
    ref_mem[8] = 16'h5A5A; ref_mem[9] = 16'hA5A5;
    model_rdata = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    chk_en = 1'b1;
    do_access(1'b1, 1'b0, 32'd1040, 32'h0);
    chk("mid_readback", obs_rd[7], 32'hA5A5_5A5A);

    // Randomized traffic over a small window plus occasional out-of-range addresses
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 2);
      d  = $urandom;
      case ($urandom_range(0, 7))
        0:       a = BASE - 4 * $urandom_range(1, 4);
        1:       a = 32'h8000_0000 + 4 * $urandom_range(0, 3);
        default: a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      endcase
      if (op == 0 && !is_oor(a) && !ref_mem.exists(int'(sram_lo(a)))) op = 1;
      do_access(op != 1, op != 0, a, d);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
